npc_predictor: RTL
==================

Name: npc_predictor

Overview:
- Next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters, giving dynamic prediction for conditional branches.
- Sits in the IF stage and drives PC_In into the PC register.
- Resolves JALR and branch outcomes in EX, and JAL in ID.
- Detects branch mispredictions in EX and signals the hazard unit to flush.

Parameters:
- XLEN, 32, PC/target width.
- BTB_ENTRIES, 64, BTB depth; power of two, minimum 4.
- IDX_W, $clog2(BTB_ENTRIES), index width (derived).
- TAG_W, XLEN-IDX_W-2, stored tag width (derived).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- PCF  in  XLEN  fetch-stage PC
- StallE  in  1  EX stage stalled; blocks BTB/counter update
- BranchInstE  in  1  conditional branch present in EX
- BranchE  in  1  resolved branch taken (valid when BranchInstE)
- PredTakenE  in  1  prediction made at fetch, piped down to EX
- PCE  in  XLEN  PC of instruction in EX
- BranchTarget  in  XLEN  resolved branch target
- JalrE  in  1  JALR in EX
- JalrTarget  in  XLEN  JALR target
- JalD  in  1  JAL in ID
- JalTarget  in  XLEN  JAL target
- PC_In  out  XLEN  next PC
- PredTakenF  out  1  fetch-stage prediction; pipeline carries it to PredTakenE
- MispredictE  out  1  branch mispredicted in EX; hazard unit flushes ID/EX

Behaviour:
- Lookup is combinational from PCF, read-before-write.
  - idx = PCF[IDX_W+1:2]; tag = PCF[XLEN-1:IDX_W+2].
  - hit = valid[idx] && tag_mem[idx]==tag.
  - PredTakenF = hit && cnt[idx][1].
- Mispredict: MispredictE = BranchInstE && (BranchE != PredTakenE). Combinational.
- PC_In priority, highest first:
  1. MispredictE: BranchE ? BranchTarget : PCE+4.
  2. JalrE: JalrTarget.
  3. JalD: JalTarget.
  4. PredTakenF: tgt_mem[idx].
  5. Otherwise PCF+4.
- All adds are modulo 2^XLEN; wrap at 0xFFFFFFFC+4 gives 0.
- Update on posedge clk when BranchInstE && !StallE, at eidx/etag taken from PCE:
  - Hit, taken: cnt = min(cnt+1, 3); tgt_mem = BranchTarget.
  - Hit, not taken: cnt = max(cnt-1, 0).
  - Miss, taken: allocate. valid=1, tag=etag, tgt=BranchTarget, cnt=2'b10 (weakly taken). Evicts any previous entry at eidx.
  - Miss, not taken: no change.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff MSB=1.
- Same-index lookup and update in one cycle: lookup returns pre-update contents.
- Reset (async, any time, including mid-update):
  - all valid=0, cnt=2'b01, tag/tgt=0.
  - PredTakenF=0 and MispredictE=0 whenever their inputs are idle.
  - Any update in flight is discarded.
- JAL and JALR are never allocated in the BTB.
- Outputs are purely combinational from inputs plus state; zero-cycle lookup latency; one-cycle update latency.

Optional Feature:
- Macro NPC_PERF_EN.
- Defined:
  - adds outputs BranchCnt[31:0] and MispredCnt[31:0].
  - Both increment on each qualifying update (BranchInstE && !StallE); MispredCnt only when MispredictE is also set.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; predictor behaviour identical.

Decomposition:
- Package npc_pkg:
  - counter encodings (SNT/WNT/WT/ST).
  - counter reset value WNT.
  - counter allocation value WT.
- Sub-module npc_btb (parameters BTB_ENTRIES, XLEN) holds valid/tag/target/counter arrays, the read port and the update logic.
- npc_predictor keeps the PC_In priority mux and mispredict detection.

Test Plan:
1. Reset, then PCF=0x100 with all controls idle -> PC_In=0x104, PredTakenF=0. Then assert rst_n low mid-run after an allocation -> PCF=0x100 misses afterwards.
2. Branch at PCE=0x100 resolved taken to 0x80 (PredTakenE=0) -> MispredictE=1, PC_In=0x80. Next cycle PCF=0x100 -> PredTakenF=1, PC_In=0x80.
3. Same branch taken twice more, then not taken with PredTakenE=1 -> MispredictE=1, PC_In=0x104. Counter goes 10→11→11→10, and the entry still predicts taken.
4. Aliasing with BTB_ENTRIES=64: allocate 0x100, then allocate 0x200 (same idx, different tag) -> PCF=0x100 now misses, PC_In=0x104.
5. Priority: JalrE=1 (0x400) and JalD=1 (0x500) with a BTB hit on PCF -> PC_In=0x400. Add a mispredict in EX instead -> mispredict target wins.
6. StallE=1 with BranchInstE=1, taken -> no allocation. Lookup in the same cycle as an update to the same idx -> returns old data. With NPC_PERF_EN: after 5 branches with 2 mispredicts -> BranchCnt=5, MispredCnt=2.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg -- shared definitions for the next-PC predictor.
//   Two-bit saturating counter encodings, the reset and allocation values,
//   and the counter step function used by the BTB update path.
package npc_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,  // strongly not taken
        WNT = 2'b01,  // weakly not taken
        WT  = 2'b10,  // weakly taken
        ST  = 2'b11   // strongly taken
    } cnt_e;

    localparam logic [1:0] CNT_RST   = WNT;
    localparam logic [1:0] CNT_ALLOC = WT;

    // Saturating step toward the resolved direction.
    function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken) begin
            if (c != ST) n = c + 2'd1;
        end else begin
            if (c != SNT) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// npc_btb -- direct-mapped branch target buffer with 2-bit counters.
//   rd_word : fetch PC without its two alignment bits
//   rd_hit / rd_taken / rd_tgt : combinational lookup result (pre-update state)
//   upd_en  : commit a resolved conditional branch this cycle
//   upd_word/upd_taken/upd_tgt : resolved branch PC (word), direction, target
// Each entry holds valid, tag, target and counter. Taken misses allocate,
// not-taken misses leave the table untouched.
module npc_btb
    import npc_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:2] rd_word,
    output logic            rd_hit,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_tgt,
    input  logic            upd_en,
    input  logic [XLEN-1:2] upd_word,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_tgt
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_mem [BTB_ENTRIES];
    logic [1:0]             cnt_mem [BTB_ENTRIES];

    logic [IDX_W-1:0] ridx, uidx;
    logic [TAG_W-1:0] rtag, utag;
    logic             uhit;

    assign ridx = rd_word[IDX_W+1:2];
    assign rtag = rd_word[XLEN-1:IDX_W+2];
    assign uidx = upd_word[IDX_W+1:2];
    assign utag = upd_word[XLEN-1:IDX_W+2];

    // Reads see only registered state, so a same-cycle update to the same
    // index is not visible until the next cycle.
    assign rd_hit   = valid[ridx] && (tag_mem[ridx] == rtag);
    assign rd_taken = rd_hit && cnt_mem[ridx][1];
    assign rd_tgt   = tgt_mem[ridx];

    assign uhit = valid[uidx] && (tag_mem[uidx] == utag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_mem[i] <= '0;
                tgt_mem[i] <= '0;
                cnt_mem[i] <= CNT_RST;
            end
        end else if (upd_en) begin
            if (uhit) begin
                cnt_mem[uidx] <= cnt_next(cnt_mem[uidx], upd_taken);
                if (upd_taken) tgt_mem[uidx] <= upd_tgt;
            end else if (upd_taken) begin
                // Allocation evicts whatever lived at this index.
                valid[uidx]   <= 1'b1;
                tag_mem[uidx] <= utag;
                tgt_mem[uidx] <= upd_tgt;
                cnt_mem[uidx] <= CNT_ALLOC;
            end
        end
    end

endmodule

// File: rtl/npc_predictor.sv
// npc_predictor -- IF-stage next-PC generator with dynamic branch prediction.
//   PCF                 : fetch PC, looked up in the BTB combinationally
//   BranchInstE/BranchE : conditional branch in EX and its resolved direction
//   PredTakenE          : the fetch-time prediction carried down to EX
//   PCE/BranchTarget    : EX branch PC and resolved target
//   StallE              : holds EX; suppresses predictor training
//   JalrE/JalrTarget    : JALR redirect from EX
//   JalD/JalTarget      : JAL redirect from ID
//   PC_In               : next PC into the PC register
//   PredTakenF          : fetch-stage taken prediction
//   MispredictE         : EX mispredict, flush request to the hazard unit
// Optional macro NPC_PERF_EN adds BranchCnt/MispredCnt saturating counters.
module npc_predictor
    import npc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCF,
    input  logic            StallE,
    input  logic            BranchInstE,
    input  logic            BranchE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] BranchTarget,
    input  logic            JalrE,
    input  logic [XLEN-1:0] JalrTarget,
    input  logic            JalD,
    input  logic [XLEN-1:0] JalTarget,
    output logic [XLEN-1:0] PC_In,
    output logic            PredTakenF,
    output logic            MispredictE
`ifdef NPC_PERF_EN
    ,
    output logic [31:0]     BranchCnt,
    output logic [31:0]     MispredCnt
`endif
);

    logic            btb_hit;
    logic [XLEN-1:0] btb_tgt;
    logic            upd_en;

    assign upd_en = BranchInstE && !StallE;

    npc_btb #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .XLEN        (XLEN)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_word   (PCF[XLEN-1:2]),
        .rd_hit    (btb_hit),
        .rd_taken  (PredTakenF),
        .rd_tgt    (btb_tgt),
        .upd_en    (upd_en),
        .upd_word  (PCE[XLEN-1:2]),
        .upd_taken (BranchE),
        .upd_tgt   (BranchTarget)
    );

    assign MispredictE = BranchInstE && (BranchE != PredTakenE);

    // Older instructions win: EX mispredict, then EX JALR, then ID JAL,
    // then the fetch-stage prediction.
    always_comb begin
        PC_In = PCF + XLEN'(4);
        if (MispredictE)     PC_In = BranchE ? BranchTarget : PCE + XLEN'(4);
        else if (JalrE)      PC_In = JalrTarget;
        else if (JalD)       PC_In = JalTarget;
        else if (PredTakenF) PC_In = btb_tgt;
    end

`ifdef NPC_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else if (upd_en) begin
            if (BranchCnt != '1) BranchCnt <= BranchCnt + 32'd1;
            if (MispredictE && MispredCnt != '1) MispredCnt <= MispredCnt + 32'd1;
        end
    end
`endif

    // btb_hit is implied by PredTakenF; kept as a named net for debug.
    logic unused_hit;
    assign unused_hit = btb_hit;

endmodule
